// File: rtl/filter_n_host_pkg.sv
// Shared definitions for the filter_n host block.
// Holds the default address/data widths, the run watchdog limit and the
// sequencing FSM state encoding used by filter_n_host.
package filter_n_host_pkg;

    localparam int AW_DEF      = 10;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERST = 3'd1,
        S_WRDY = 3'd2,
        S_STRT = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/filter_sample_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Ports:
//   clk, rst      clock; rst clears only the read data register, not the array
//   we/waddr/wdata write port
//   raddr/rdata   read port, 1-cycle latency; a read of the address being
//                 written in the same cycle returns the old contents
module filter_sample_ram
    import filter_n_host_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/filter_n_host.sv
// Host-side companion of the filter_n sequencer.
// Owns the input sample RAM (host-written, streamed to the sequencer) and the
// output result RAM (written from the sequencer, host-read), and sequences a
// run: reset sequencer, wait ready, start, collect results, finish.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   h_we/h_waddr/h_wdata        host write into input RAM (dropped while busy)
//   h_raddr/h_rdata             host read of output RAM, 1-cycle latency
//   h_end, h_go                 sample count and start pulse
//   h_busy, h_done, h_err       run status; h_err is a sticky watchdog abort
//   h_count                     results written in the last run
//   eng_rst, eng_start          control pulses to the sequencer
//   eng_ready, eng_valid        sequencer status (valid sticky until eng_rst)
//   eng_inc, eng_dout           result advance strobe and result data
//   eng_addr, eng_end, eng_din  sample index, end index, sample data
//
// state | meaning
// IDLE  | waiting for h_go
// ERST  | one-cycle reset pulse to the sequencer
// WRDY  | waiting for eng_ready
// STRT  | one-cycle start pulse to the sequencer, watchdog armed
// RUN   | capturing results on eng_inc / eng_valid rising edge
// DONE  | one-cycle h_done pulse
module filter_n_host
    import filter_n_host_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = 2 ** AW,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          h_we,
    input  logic [AW-1:0] h_waddr,
    input  logic [DW-1:0] h_wdata,
    input  logic [AW-1:0] h_raddr,
    output logic [DW-1:0] h_rdata,
    input  logic [AW-1:0] h_end,
    input  logic          h_go,
    output logic          h_busy,
    output logic          h_done,
    output logic          h_err,
    output logic [AW:0]   h_count,
    output logic          eng_rst,
    output logic          eng_start,
    input  logic          eng_ready,
    input  logic          eng_valid,
    input  logic          eng_inc,
    output logic [AW-1:0] eng_addr,
    output logic [AW-1:0] eng_end,
    output logic [DW-1:0] eng_din,
    input  logic [DW-1:0] eng_dout
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  end_q;
    logic [AW:0]    count_q;
    logic           err_q;
    logic           valid_q;
    logic [WDW-1:0] wd_q;

    logic valid_rise;
    logic inc_ok;
    logic wd_expired;
    logic go_ok;
    logic out_we;
    logic adv;
    logic cnt_inc;
    logic wd_load;
    logic err_set;

    assign valid_rise = eng_valid & ~valid_q;
    // The last index is reached by the valid edge, never by an inc, so an inc
    // arriving at end-1 (or in a zero-length run) is ignored.
    assign inc_ok     = eng_inc && (end_q != '0) && (addr_q != end_q - AW'(1));
    assign wd_expired = (wd_q == WDW'(1));

    always_comb begin
        state_d = state_q;
        go_ok   = 1'b0;
        out_we  = 1'b0;
        adv     = 1'b0;
        cnt_inc = 1'b0;
        wd_load = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (h_go) begin
                    go_ok   = 1'b1;
                    state_d = S_ERST;
                end
            end
            S_ERST: state_d = S_WRDY;
            S_WRDY: begin
                if (eng_ready) begin
                    state_d = S_STRT;
                end
            end
            S_STRT: begin
                wd_load = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_inc) begin
                    wd_load = 1'b1;
                    if (inc_ok) begin
                        out_we  = 1'b1;
                        adv     = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                if (valid_rise) begin
                    // With a coincident inc the single write port is taken by
                    // the inc result; the final result is then lost.
                    if (!inc_ok && (end_q != '0)) begin
                        out_we  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (!eng_inc && wd_expired) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            // Forcing the history high in ERST masks a valid still held over
            // from the previous run; only a fresh rising edge completes a run.
            valid_q <= (state_q == S_ERST) ? 1'b1 : eng_valid;
            if (go_ok) begin
                end_q   <= h_end;
                count_q <= '0;
                err_q   <= 1'b0;
                addr_q  <= '0;
            end
            if (adv) begin
                addr_q <= addr_q + AW'(1);
            end
            if (cnt_inc) begin
                count_q <= count_q + (AW+1)'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (wd_load) begin
                wd_q <= WDW'(TIMEOUT);
            end else if (state_q == S_RUN) begin
                wd_q <= wd_q - WDW'(1);
            end
        end
    end

    assign h_busy    = (state_q inside {S_ERST, S_WRDY, S_STRT, S_RUN});
    assign h_done    = (state_q == S_DONE);
    assign eng_rst   = (state_q == S_ERST);
    assign eng_start = (state_q == S_STRT);
    assign h_err     = err_q;
    assign h_count   = count_q;
    assign eng_addr  = addr_q;
    assign eng_end   = end_q;

    filter_sample_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_in_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (h_we && !h_busy),
        .waddr (h_waddr),
        .wdata (h_wdata),
        .raddr (addr_q),
        .rdata (eng_din)
    );

    filter_sample_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_out_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (out_we && !rst),
        .waddr (addr_q),
        .wdata (eng_dout),
        .raddr (h_raddr),
        .rdata (h_rdata)
    );

    // A conforming sequencer never advances and completes in the same cycle.
    a_no_inc_on_valid_edge: assert property (
        @(posedge clk) disable iff (rst)
        !((state_q == S_RUN) && eng_inc && valid_rise)
    );

endmodule

// File: tb/tb_filter_n_host.sv
module tb_filter_n_host;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_we;
    logic [AW-1:0] h_waddr;
    logic [DW-1:0] h_wdata;
    logic [AW-1:0] h_raddr;
    logic [DW-1:0] h_rdata;
    logic [AW-1:0] h_end;
    logic          h_go;
    logic          h_busy;
    logic          h_done;
    logic          h_err;
    logic [AW:0]   h_count;
    logic          eng_rst;
    logic          eng_start;
    logic          eng_ready;
    logic          eng_valid;
    logic          eng_inc;
    logic [AW-1:0] eng_addr;
    logic [AW-1:0] eng_end;
    logic [DW-1:0] eng_din;
    logic [DW-1:0] eng_dout;

    always #5 clk = ~clk;

    filter_n_host dut (
        .clk       (clk),
        .rst       (rst),
        .h_we      (h_we),
        .h_waddr   (h_waddr),
        .h_wdata   (h_wdata),
        .h_raddr   (h_raddr),
        .h_rdata   (h_rdata),
        .h_end     (h_end),
        .h_go      (h_go),
        .h_busy    (h_busy),
        .h_done    (h_done),
        .h_err     (h_err),
        .h_count   (h_count),
        .eng_rst   (eng_rst),
        .eng_start (eng_start),
        .eng_ready (eng_ready),
        .eng_valid (eng_valid),
        .eng_inc   (eng_inc),
        .eng_addr  (eng_addr),
        .eng_end   (eng_end),
        .eng_din   (eng_din),
        .eng_dout  (eng_dout)
    );

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int done_cnt  = 0;
    int erst_cnt  = 0;
    int start_cnt = 0;
    int erst_cyc  = 0;
    int start_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (h_done)    done_cnt <= done_cnt + 1;
        if (eng_rst)   begin erst_cnt  <= erst_cnt + 1;  erst_cyc  <= cyc; end
        if (eng_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
    end

    logic [DW-1:0] ref_in  [1024];
    logic [DW-1:0] ref_out [1024];

    // Single-precision x + 1.0 for normal numbers, via exact widening to double.
    function automatic logic [DW-1:0] fadd1(input logic [DW-1:0] x);
        logic [63:0] d;
        real         r;
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) return x;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        r = $bitstoreal(d) + 1.0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Behavioural filter_n sequencer: dout = din + 1.0, inc per sample except
    // the last, which is delivered with a sticky valid.
    int stall_after = -1;
    bit extra_inc   = 1'b0;
    int last_inc_edge = 0;

    initial begin : seq_model
        logic          s_rst, s_erst, s_start;
        logic [DW-1:0] s_din;
        logic [AW-1:0] s_end;
        bit            active;
        bit            extra_done;
        int            n, k, wt;
        active = 1'b0; extra_done = 1'b0; n = 0; k = 0; wt = 0;
        eng_ready = 1'b1;
        eng_valid = 1'b0;
        eng_inc   = 1'b0;
        eng_dout  = '0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_erst = eng_rst; s_start = eng_start;
            s_din = eng_din; s_end = eng_end;
            @(posedge clk);
            #1;
            eng_inc = 1'b0;
            if (s_rst || s_erst) begin
                active = 1'b0;
                eng_valid = 1'b0;
            end else if (s_start) begin
                active = 1'b1; n = int'(s_end); k = 0; wt = 2; extra_done = 1'b0;
            end else if (active) begin
                if (wt > 0) begin
                    wt--;
                end else if (n == 0) begin
                    eng_valid = 1'b1; active = 1'b0;
                end else if (k < n - 1) begin
                    if (k == stall_after) begin
                        active = 1'b0;
                    end else begin
                        eng_dout = fadd1(s_din); eng_inc = 1'b1; k++; wt = 3;
                        last_inc_edge = cyc + 1;
                    end
                end else if (extra_inc && !extra_done) begin
                    eng_dout = 32'hDEAD_BEEF; eng_inc = 1'b1; extra_done = 1'b1; wt = 3;
                end else begin
                    eng_dout = fadd1(s_din); eng_valid = 1'b1; active = 1'b0;
                end
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        h_we = 1'b1; h_waddr = a; h_wdata = d;
        @(posedge clk); #1;
        h_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        h_raddr = a;
        @(posedge clk); #1;
        d = h_rdata;
    endtask

    task automatic load_random(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
            host_write(AW'(i), d);
            ref_in[i] = d;
        end
    endtask

    task automatic pulse_go(input int e);
        h_end = AW'(e); h_go = 1'b1;
        @(posedge clk); #1;
        h_go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (h_done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (h_done !== 1'b1) begin
            failures++;
            $display("FAIL %s: h_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] got [10];
        string         nm  [10];
        rst = 1'b1; h_we = 1'b0; h_go = 1'b0; h_waddr = '0; h_wdata = '0;
        h_raddr = '0; h_end = '0;
        repeat (3) @(posedge clk);
        #1;
        got = '{DW'(h_busy), DW'(h_done), DW'(h_err), DW'(eng_start), DW'(eng_rst),
                DW'(eng_addr), DW'(h_count), DW'(eng_end), eng_din, h_rdata};
        nm  = '{"h_busy", "h_done", "h_err", "eng_start", "eng_rst",
                "eng_addr", "h_count", "eng_end", "eng_din", "h_rdata"};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== '0) begin
                failures++;
                $display("FAIL reset_%s: got %0h want 0", nm[i], got[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] vin [4];
        logic [DW-1:0] vexp [4];
        logic [DW-1:0] d;
        int d0;
        vin  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        vexp = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        for (int i = 0; i < 4; i++) begin
            host_write(AW'(i), vin[i]);
            ref_in[i] = vin[i];
        end
        d0 = done_cnt;
        pulse_go(4);
        checks++;
        if (eng_end !== AW'(4) || h_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_go: eng_end=%0d busy=%0b want 4/1", eng_end, h_busy);
        end
        wait_done(300, "basic_done");
        checks++;
        if (h_count !== 11'd4 || h_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_count: h_count=%0d h_err=%0b want 4/0", h_count, h_err);
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt - d0 != 1 || h_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulses: dones=%0d busy=%0b want 1/0", done_cnt - d0, h_busy);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(AW'(i), d);
            ref_out[i] = vexp[i];
            checks++;
            if (d !== vexp[i]) begin
                failures++;
                $display("FAIL basic_out[%0d]: got %h want %h", i, d, vexp[i]);
            end
        end
    endtask

    task automatic test_zero();
        logic [DW-1:0] d;
        int r0, s0, d0;
        r0 = erst_cnt; s0 = start_cnt; d0 = done_cnt;
        pulse_go(0);
        wait_done(10, "zero_done");
        checks++;
        if (h_count !== '0) begin
            failures++;
            $display("FAIL zero_count: got %0d want 0", h_count);
        end
        @(posedge clk); #1;
        checks++;
        if (erst_cnt - r0 != 1 || start_cnt - s0 != 1 || !(erst_cyc < start_cyc) || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_pulses: rst=%0d start=%0d order=%0d/%0d done=%0d want 1/1/rst<start/1",
                     erst_cnt - r0, start_cnt - s0, erst_cyc, start_cyc, done_cnt - d0);
        end
        host_read('0, d);
        checks++;
        if (d !== ref_out[0]) begin
            failures++;
            $display("FAIL zero_nowrite: out[0]=%h want %h", d, ref_out[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int r0, d0;
        int lens [2];
        lens = '{2, 3};
        load_random(3);
        r0 = erst_cnt; d0 = done_cnt;
        for (int run = 0; run < 2; run++) begin
            pulse_go(lens[run]);
            wait_done(300, "b2b_done");
            checks++;
            if (h_count !== 11'(lens[run])) begin
                failures++;
                $display("FAIL b2b_count run%0d: got %0d want %0d", run, h_count, lens[run]);
            end
            @(posedge clk); #1;
            checks++;
            if (erst_cnt - r0 != run + 1 || done_cnt - d0 != run + 1) begin
                failures++;
                $display("FAIL b2b_pulses run%0d: eng_rst=%0d done=%0d want %0d", run,
                         erst_cnt - r0, done_cnt - d0, run + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            host_read(AW'(i), d);
            ref_out[i] = fadd1(ref_in[i]);
            checks++;
            if (d !== ref_out[i]) begin
                failures++;
                $display("FAIL b2b_out[%0d]: got %h want %h", i, d, ref_out[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d;
        int d0, n;
        load_random(4);
        stall_after = 1;
        d0 = done_cnt;
        pulse_go(4);
        n = 0;
        while (h_err !== 1'b1 && n < TIMEOUT + 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (h_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err: h_err=%0b want 1", h_err);
        end
        checks++;
        if (cyc - last_inc_edge != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", cyc - last_inc_edge, TIMEOUT);
        end
        checks++;
        if (h_done !== 1'b1 || h_count !== 11'd1) begin
            failures++;
            $display("FAIL timeout_done: h_done=%0b h_count=%0d want 1/1", h_done, h_count);
        end
        @(posedge clk); #1;
        checks++;
        if (h_busy !== 1'b0 || h_done !== 1'b0 || done_cnt - d0 != 1 || h_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_idle: busy=%0b done=%0b dones=%0d err=%0b want 0/0/1/1",
                     h_busy, h_done, done_cnt - d0, h_err);
        end
        stall_after = -1;
        host_read('0, d);
        ref_out[0] = fadd1(ref_in[0]);
        checks++;
        if (d !== ref_out[0]) begin
            failures++;
            $display("FAIL timeout_out0: got %h want %h", d, ref_out[0]);
        end
    endtask

    task automatic test_reset_midrun();
        logic [DW-1:0] d;
        int d0, n;
        load_random(6);
        d0 = done_cnt;
        pulse_go(6);
        n = 0;
        while (h_count !== 11'd2 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (h_count !== 11'd2) begin
            failures++;
            $display("FAIL midrst_reach: h_count=%0d want 2", h_count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (h_busy !== 1'b0 || eng_addr !== '0 || h_done !== 1'b0 || h_count !== '0) begin
            failures++;
            $display("FAIL midrst_state: busy=%0b addr=%0d done=%0b count=%0d want 0/0/0/0",
                     h_busy, eng_addr, h_done, h_count);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL midrst_nodone: dones=%0d want 0", done_cnt - d0);
        end
        for (int i = 0; i < 2; i++) begin
            host_read(AW'(i), d);
            ref_out[i] = fadd1(ref_in[i]);
            checks++;
            if (d !== ref_out[i]) begin
                failures++;
                $display("FAIL midrst_out[%0d]: got %h want %h", i, d, ref_out[i]);
            end
        end
    endtask

    task automatic test_ignore();
        logic [DW-1:0] d;
        int r0, d0;
        load_random(5);
        r0 = erst_cnt; d0 = done_cnt;
        pulse_go(5);
        repeat (3) @(posedge clk);
        #1;
        h_go = 1'b1; h_end = AW'(2);
        h_we = 1'b1; h_waddr = AW'(4); h_wdata = ref_in[4] ^ 32'h0000_0F0F;
        @(posedge clk); #1;
        h_go = 1'b0; h_we = 1'b0;
        wait_done(300, "ignore_done");
        checks++;
        if (h_count !== 11'd5 || eng_end !== AW'(5)) begin
            failures++;
            $display("FAIL ignore_count: h_count=%0d eng_end=%0d want 5/5", h_count, eng_end);
        end
        @(posedge clk); #1;
        checks++;
        if (erst_cnt - r0 != 1 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignore_pulses: eng_rst=%0d done=%0d want 1/1", erst_cnt - r0, done_cnt - d0);
        end
        for (int i = 0; i < 5; i++) begin
            host_read(AW'(i), d);
            ref_out[i] = fadd1(ref_in[i]);
            checks++;
            if (d !== ref_out[i]) begin
                failures++;
                $display("FAIL ignore_out[%0d]: got %h want %h", i, d, ref_out[i]);
            end
        end
    endtask

    task automatic test_random_runs();
        logic [DW-1:0] d;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 1 : int'($urandom_range(2, 20));
            extra_inc = (r == 2);
            load_random(n);
            pulse_go(n);
            wait_done(600, "rand_done");
            checks++;
            if (h_count !== 11'(n) || h_err !== 1'b0 || eng_addr !== AW'(n - 1)) begin
                failures++;
                $display("FAIL rand_count run%0d: count=%0d err=%0b addr=%0d want %0d/0/%0d",
                         r, h_count, h_err, eng_addr, n, n - 1);
            end
            @(posedge clk); #1;
            extra_inc = 1'b0;
            for (int i = 0; i < n; i++) begin
                host_read(AW'(i), d);
                ref_out[i] = fadd1(ref_in[i]);
                checks++;
                if (d !== ref_out[i]) begin
                    failures++;
                    $display("FAIL rand_out run%0d [%0d]: got %h want %h", r, i, d, ref_out[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_timeout();
        test_reset_midrun();
        test_ignore();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_n_host.md
Name: filter_n_host

Overview:
- Host-side counterpart of the filter_n sequencer.
- Owns the input sample RAM and output result RAM, and drives the sequencer's start/end controls.
- Serves sample data on the sequencer's addr/inc stream and captures each filtered output as it is produced.
- Sits between the system/host bus and the filter sequencer; exposes a simple go/busy/done control interface.

Parameters:
- AW, 10, address width; matches sequencer addr/endAddr width.
- DW, 32, sample width (IEEE-754 single).
- DEPTH, 1024, entries per RAM (= 2**AW).
- TIMEOUT, 4096, max RUN cycles without eng_inc/eng_valid activity before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- h_we  in  1  host write strobe, input RAM
- h_waddr  in  AW  host write address
- h_wdata  in  DW  host write data
- h_raddr  in  AW  host read address, output RAM
- h_rdata  out  DW  output RAM read data, 1-cycle latency
- h_end  in  AW  number of samples to process, sampled on h_go
- h_go  in  1  start-run pulse
- h_busy  out  1  run in progress
- h_done  out  1  one-cycle pulse at end of run (normal or abort)
- h_err  out  1  sticky timeout flag; cleared by next accepted h_go
- h_count  out  AW+1  results written in last run
- eng_rst  out  1  one-cycle reset to sequencer
- eng_start  out  1  start pulse to sequencer
- eng_ready  in  1  sequencer ready
- eng_valid  in  1  sequencer done (sticky until eng_rst)
- eng_inc  in  1  sequencer advance pulse, coincident with new eng_dout
- eng_addr  out  AW  current sample index
- eng_end  out  AW  end address (latched h_end)
- eng_din  out  DW  sample at eng_addr (registered RAM read)
- eng_dout  in  DW  filtered result

Behaviour:
- Reset values:
  - h_busy, h_done, h_err, eng_start, eng_addr: 0
  - h_count, eng_end, eng_din, h_rdata: 0
  - eng_rst: 0
  - FSM: IDLE
- RAM contents are not cleared by rst.
- FSM states:
  - IDLE: on h_go, latch eng_end = h_end, clear h_err/h_count, set eng_addr = 0, set h_busy → ERST.
  - ERST: eng_rst = 1 for exactly one cycle. Clears the sequencer's sticky valid from any previous run. → WRDY.
  - WRDY: wait for eng_ready = 1 → STRT.
  - STRT: eng_start = 1 for one cycle; reset watchdog → RUN.
  - RUN:
    - eng_inc = 1: write eng_dout to out_mem[eng_addr], eng_addr += 1, h_count += 1, reset watchdog.
    - Rising edge of eng_valid:
      - If eng_end != 0, write eng_dout to out_mem[eng_addr] and increment h_count.
      - → DONE.
    - Watchdog reaches TIMEOUT: h_err = 1 → DONE.
  - DONE: h_done = 1 for one cycle, h_busy = 0 → IDLE.
- Valid-edge detector is cleared in ERST so a stale high eng_valid is never taken as completion.
- eng_din is the registered read in_mem[eng_addr]: one cycle after any eng_addr change. The sequencer's post-inc wait is ≥3 cycles, so din is stable before the next fil_start.
- Boundary conditions:
  - h_end = 0: sequencer finishes immediately; no write, h_count = 0, h_done pulses.
  - h_end = 1: no inc; single write at addr 0 on valid.
  - General case: writes at 0..h_end−2 via inc, h_end−1 via valid; h_count = h_end.
  - eng_addr never exceeds eng_end−1; an eng_inc at that point is ignored and does not write.
  - Simultaneous eng_inc and valid-edge: perform the inc write first, then complete. This case must not occur with a conforming sequencer; it is flagged by an assertion.
  - h_go while h_busy: ignored.
  - h_we while h_busy: dropped; input RAM is frozen during a run.
  - Host reads (h_raddr) are allowed anytime. Reading an address being written in the same cycle returns old data.
  - rst mid-run: immediate return to IDLE, outputs to reset values, no h_done pulse.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ERST, WRDY, STRT, RUN, DONE)
  - AW/DW defaults
  - TIMEOUT default
- One sub-module: filter_sample_ram, a simple dual-port synchronous RAM (1 write port, 1 registered read port).
  - Instanced twice: input RAM, output RAM.

Test Plan:
- Load in_mem[0..3] = 1.0, 2.0, 3.0, 4.0; h_end = 4; go with sequencer model returning din+1.0. Required: out_mem = 2.0, 3.0, 4.0, 5.0; h_count = 4; one h_done; h_err = 0.
- h_end = 0, go. Required: eng_rst then eng_start pulses, no RAM writes, h_count = 0, h_done within 10 cycles.
- Two back-to-back runs (h_end = 2, then 3) with eng_valid held high between runs. Required: second run does not complete before 3 results; eng_rst pulses once per run.
- Model stalls after first inc. Required: h_err = 1 exactly TIMEOUT cycles after last activity, h_done pulse, FSM in IDLE, h_count = 1.
- Assert rst in RUN after 2 incs. Required: next cycle h_busy = 0, eng_addr = 0, no h_done; RAM retains the 2 written results.
- h_go and h_we pulsed during a run. Required: both ignored; in_mem unchanged; run completes normally.
